// File: rtl/serial_rev_alu_seq_if.sv
// Handshake bundle between the operand/opcode source, the bit-serial ALU
// sequencer and the result consumer. The master is the source/consumer
// side and the slave is the sequencer.
interface serial_rev_alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/serial_rev_alu_seq.sv
// Bit-serial sequencer around one reversible 1-bit ALU slice. Operands are
// captured in IDLE, processed LSB first over WIDTH RUN cycles, and the
// result word plus flags are presented in HOLD until the consumer takes it.
module serial_rev_alu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_rev_alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  // Feynman (CNOT) target output: q = a ^ b. The control passthrough is garbage.
  function automatic logic feynman(input logic a, input logic b);
    return a ^ b;
  endfunction

  // Toffoli target output: r = c ^ (a & b). Controls pass through as garbage.
  function automatic logic toffoli(input logic a, input logic b, input logic c);
    return c ^ (a & b);
  endfunction

  // Double Peres gate, {r, s} outputs only. With d=0, r is the full-adder sum
  // and s the carry; p and q are garbage.
  function automatic logic [1:0] dpg(input logic a, input logic b,
                                     input logic c, input logic d);
    logic r;
    logic s;
    r = a ^ b ^ c;
    s = ((a ^ b) & c) ^ (a & b) ^ d;
    return {r, s};
  endfunction

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_result_q;
  logic             out_cout_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  logic             b_eff;
  logic             sum_bit;
  logic             carry_gen;
  logic             xor_bit;
  logic             slice_bit;
  logic             arith;
  logic [WIDTH-1:0] r_next;

  // One slice evaluation on the current LSBs and carry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    slice_bit = 1'b0;
    arith     = (op_q == OP_ADD) || (op_q == OP_SUB);
    // SUB adds ~B with carry-in 1; the inversion is a Feynman with control tied high.
    b_eff     = (op_q == OP_SUB) ? feynman(1'b1, b_sr[0]) : b_sr[0];
    {sum_bit, carry_gen} = dpg(a_sr[0], b_eff, carry, 1'b0);
    xor_bit   = feynman(a_sr[0], b_sr[0]);
    case (op_q)
      OP_ADD,
      OP_SUB:   slice_bit = sum_bit;
      OP_AND:   slice_bit = toffoli(a_sr[0], b_sr[0], 1'b0);
      // (a ^ b) ^ (a & b) == a | b
      OP_OR:    slice_bit = toffoli(a_sr[0], b_sr[0], xor_bit);
      OP_XOR:   slice_bit = xor_bit;
      OP_XNOR:  slice_bit = feynman(1'b1, xor_bit);
      OP_NOTA:  slice_bit = feynman(1'b1, a_sr[0]);
      OP_PASSB: slice_bit = b_sr[0];
      default:  slice_bit = 1'b0;
    endcase
    r_next = {slice_bit, r_sr[WIDTH-1:1]};
  end

  // Sequencer FSM with registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_ADD;
      cnt          <= '0;
      carry        <= 1'b0;
      a_sr         <= '0;
      b_sr         <= '0;
      r_sr         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_zero_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.in_a;
            b_sr  <= bus.in_b;
            op_q  <= op_e'(bus.in_op);
            carry <= (bus.in_op == OP_SUB);
            cnt   <= '0;
            r_sr  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr <= {1'b0, b_sr[WIDTH-1:1]};
          r_sr <= r_next;
          if (arith) carry <= carry_gen;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Here the carry register still holds the carry into the MSB.
            out_result_q <= r_next;
            out_cout_q   <= arith & carry_gen;
            out_ovf_q    <= arith & (carry ^ carry_gen);
            out_zero_q   <= (r_next == '0);
            out_valid_q  <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_zero   = out_zero_q;

endmodule

// File: tb/tb_serial_rev_alu_seq.sv
// Directed bench for serial_rev_alu_seq: arithmetic and logic vectors,
// latency, backpressure, input stability during RUN and async reset abort.
module tb_serial_rev_alu_seq;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  serial_rev_alu_seq_if #(.WIDTH(WIDTH)) bus ();

  serial_rev_alu_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] r,
                               input logic c, input logic o, input logic z);
    check({tag, ".res"},  32'(bus.out_result), 32'(r));
    check({tag, ".cout"}, 32'(bus.out_cout), 32'(c));
    check({tag, ".ovf"},  32'(bus.out_ovf), 32'(o));
    check({tag, ".zero"}, 32'(bus.out_zero), 32'(z));
  endtask

  // Issue one operation, check latency and result, optionally backpressure
  // for `hold` cycles and optionally scramble inputs during RUN.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [15:0] exp_r,
                        input logic exp_c, input logic exp_o,
                        input int hold, input bit scramble);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      tick;
      k++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = scramble;
    check({tag, ".busy"}, 32'(bus.in_ready), 32'd0);
    k = 0;
    while (!bus.out_valid && k < 40) begin
      if (scramble) begin
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
        bus.in_op = 3'($urandom);
      end
      tick;
      k++;
    end
    bus.in_valid = 1'b0;
    check({tag, ".latency"}, 32'(k), 32'(WIDTH));
    check_outputs(tag, exp_r, exp_c, exp_o, exp_r == 16'h0000);
    for (int h = 0; h < hold; h++) begin
      bus.in_a = ~bus.in_a;
      bus.in_b = bus.in_b ^ 16'h5a5a;
      bus.in_valid = ~bus.in_valid;
      tick;
      check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      check_outputs({tag, ".hold"}, exp_r, exp_c, exp_o, exp_r == 16'h0000);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    check({tag, ".drop_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int k;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.ready", 32'(bus.in_ready), 32'd1);
    check_outputs("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;

    run_op("add_ovf",   16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b1, 0, 1'b0);

    // Abort an ADD at RUN bit 7 with an asynchronous reset.
    k = 0;
    while (!bus.in_ready && k < 50) begin
      tick;
      k++;
    end
    bus.in_a = 16'hAAAA;
    bus.in_b = 16'h5555;
    bus.in_op = 3'b000;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(bus.out_valid), 32'd0);
    check("arst.ready", 32'(bus.in_ready), 32'd1);
    check_outputs("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    check("arst.no_result", 32'(bus.out_valid), 32'd0);
    run_op("add_fresh", 16'h1234, 16'h1111, 3'b000, 16'h2345, 1'b0, 1'b0, 0, 1'b0);

    run_op("add_wrap",  16'hFFFF, 16'h0001, 3'b000, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_eq",    16'h0005, 16'h0005, 3'b001, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_neg",   16'h0003, 16'h0005, 3'b001, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
    run_op("and",       16'hF0F0, 16'h3C3C, 3'b010, 16'h3030, 1'b0, 1'b0, 0, 1'b0);
    run_op("or",        16'hF0F0, 16'h3C3C, 3'b011, 16'hFCFC, 1'b0, 1'b0, 0, 1'b0);
    run_op("xor",       16'hF0F0, 16'h3C3C, 3'b100, 16'hCCCC, 1'b0, 1'b0, 0, 1'b0);
    run_op("xnor",      16'hF0F0, 16'h3C3C, 3'b101, 16'h3333, 1'b0, 1'b0, 0, 1'b0);
    run_op("nota",      16'hF0F0, 16'h3C3C, 3'b110, 16'h0F0F, 1'b0, 1'b0, 0, 1'b0);
    run_op("passb",     16'hF0F0, 16'h3C3C, 3'b111, 16'h3C3C, 1'b0, 1'b0, 0, 1'b0);
    run_op("backpress", 16'h7FFF, 16'h0001, 3'b000, 16'h8000, 1'b0, 1'b1, 5, 1'b0);
    run_op("scramble",  16'h00FF, 16'h0F01, 3'b000, 16'h1000, 1'b0, 1'b0, 0, 1'b1);
    run_op("sub_scr",   16'h8000, 16'h0001, 3'b001, 16'h7FFF, 1'b1, 1'b1, 2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_rev_alu_seq.md
Name: serial_rev_alu_seq

Overview:
- Bit-serial sequencer that drives one reversible 1-bit ALU slice over WIDTH cycles, LSB first, to produce a full-word result.
- The slice is built from the existing gate library:
  - DPG with d=0 provides sum on r and carry on s.
  - Feynman provides XOR and the operand-B inversion for SUB.
  - Toffoli with c=0 provides AND.
  - Garbage outputs are left unconnected.
- Sits between the operand/opcode source and the result consumer in the 16-bit ALU. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; also the number of RUN cycles.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode request.
- in_ready  out  1  high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  opcode: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result word.
- out_cout  out  1  carry out for ADD/SUB (SUB: 1 = no borrow); 0 for logic ops.
- out_ovf  out  1  signed overflow for ADD/SUB; 0 for logic ops.
- out_zero  out  1  out_result == 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Asserting rst_n=0 forces the following immediately, regardless of clk:
  - state = IDLE.
  - Bit counter, carry register, and A/B/result shift registers = 0.
  - out_valid = 0, out_result = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - in_ready = 1 (decoded from IDLE).
- Reset mid-RUN or mid-HOLD aborts the operation; no partial result is ever presented.
- States: IDLE, RUN, HOLD.
- IDLE: in_ready = 1.
  - On an edge with in_valid=1, capture in_a, in_b, in_op into shift registers.
  - Carry register loads 1 for SUB, 0 otherwise.
  - Counter loads 0; go to RUN.
- RUN: in_ready = 0; input changes are ignored. Each edge:
  - Compute slice on A[0], B'[0] and carry, where B' = ~B for SUB, B otherwise.
  - Shift the slice output into result MSB; shift A and B right by 1.
  - Update carry from the DPG s output (ADD/SUB only; held otherwise).
  - Increment counter.
  - Latch carry-into-MSB when counter == WIDTH-1.
- On the edge where counter == WIDTH-1, go to HOLD. out_valid rises exactly WIDTH edges after the accept edge.
- HOLD: out_valid = 1.
  - out_result and all flags are stable and must not change while out_valid=1 and out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1: go to IDLE and drop out_valid. in_ready is high on the following cycle.
  - No acceptance in the same cycle as result handoff; throughput is one op per WIDTH+2 cycles minimum.
- Flags are computed at HOLD entry:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out.
  - zero = result==0, for all ops.
- Logic ops: cout = 0, ovf = 0.
- NOT A ignores B; PASS B ignores A.
- in_valid high while not in IDLE has no effect; the request is held by the source until in_ready.
- Counter never exceeds WIDTH-1; no wrap into a second pass.

Test Plan:
- ADD 0x7FFF + 0x0001 -> out_result 0x8000, cout 0, ovf 1, zero 0; out_valid rises 16 edges after accept.
- ADD 0xFFFF + 0x0001 -> 0x0000, cout 1, ovf 0, zero 1. SUB 0x0005 - 0x0005 -> 0x0000, cout 1, zero 1. SUB 0x0003 - 0x0005 -> 0xFFFE, cout 0, ovf 0.
- Logic, A=0xF0F0, B=0x3C3C:
  - AND -> 0x3030; OR -> 0xFCFC; XOR -> 0xCCCC; XNOR -> 0x3333.
  - NOT A -> 0x0F0F; PASS B -> 0x3C3C.
  - cout=ovf=0 for all.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD, toggling in_a/in_b/in_valid -> result/flags unchanged, in_ready 0; out_ready=1 -> IDLE, in_ready=1 next cycle.
- Input stability: change in_a/in_b/in_op every cycle during RUN -> result reflects only the captured operands.
- Async reset: assert rst_n=0 mid-cycle at RUN bit 7 -> all outputs 0 and in_ready 1 immediately, before next edge; after release, a fresh ADD 0x1234 + 0x1111 -> 0x2345.
